// File: rtl/washer_sensor_model.sv
// ---------------------------------------------------------------------------
// washer_sensor_model
//   Behavioural sensor model for a washing-machine controller. It watches the
//   controller's state code and door input each clock and produces the
//   water-level, detergent, timer and drain feedback the controller expects.
//
// Parameters
//   WATER_FULL  : FILL samples needed to reach the full water level (1..255)
//   DET_FULL    : DETERGENT samples needed to reach the full dose   (1..255)
//   WASH_CYCLES : WASH samples before cycle_time_out                 (1..65535)
//   SPIN_CYCLES : SPIN samples before spin_time_out                  (1..65535)
//
// Ports
//   clk                         in   rising-edge clock
//   reset                       in   asynchronous, active-high reset
//   state[2:0]                  in   controller state code (110/111 illegal)
//   door_closed                 in   1 = door closed
//   water_level_decrease        out  1 while water_level < WATER_FULL
//   detergent_quantity_decrease out  1 while detergent dose < DET_FULL
//   cycle_time_out              out  wash timer expired
//   drained                     out  drum empty during DRAIN
//   spin_time_out               out  spin timer expired
//   water_level[7:0]            out  current water level count
//   fault                       out  sticky illegal-state / door-open flag
// ---------------------------------------------------------------------------
module washer_sensor_model #(
  parameter int WATER_FULL  = 4,
  parameter int DET_FULL    = 3,
  parameter int WASH_CYCLES = 3,
  parameter int SPIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic       door_closed,
  output logic       water_level_decrease,
  output logic       detergent_quantity_decrease,
  output logic       cycle_time_out,
  output logic       drained,
  output logic       spin_time_out,
  output logic [7:0] water_level,
  output logic       fault
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_FILL      = 3'b001,
    ST_DETERGENT = 3'b010,
    ST_WASH      = 3'b011,
    ST_DRAIN     = 3'b100,
    ST_SPIN      = 3'b101
  } state_e;

  localparam logic [7:0]  WATER_FULL_C  = 8'(WATER_FULL);
  localparam logic [7:0]  DET_FULL_C    = 8'(DET_FULL);
  localparam logic [15:0] WASH_CYCLES_C = 16'(WASH_CYCLES);
  localparam logic [15:0] SPIN_CYCLES_C = 16'(SPIN_CYCLES);

  function automatic logic [7:0] inc_sat8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  function automatic logic [7:0] dec_sat8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  function automatic logic [15:0] inc_sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0]  det_count;
  logic [15:0] timer;
  state_e      prev_state;

  logic [7:0]  level_n;
  logic [7:0]  det_n;
  logic [15:0] timer_n;
  state_e      prev_n;
  logic        cto_n;
  logic        drained_n;
  logic        sto_n;
  logic        fault_n;

  logic        legal;
  logic        timed;
  logic        is_wash;
  logic        is_spin;

  assign legal   = (state <= 3'b101);
  assign is_wash = (state == ST_WASH);
  assign is_spin = (state == ST_SPIN);
  assign timed   = is_wash | is_spin;

  always_comb begin
    level_n   = water_level;
    det_n     = det_count;
    timer_n   = timer;
    prev_n    = prev_state;
    cto_n     = cycle_time_out;
    drained_n = drained;
    sto_n     = spin_time_out;
    fault_n   = fault;

    if (!legal) begin
      // Illegal code: everything freezes, including prev_state, so the
      // next legal sample is compared against the last legal one.
      fault_n = 1'b1;
    end else if ((state != ST_IDLE) && !door_closed) begin
      fault_n = 1'b1;
    end else begin
      prev_n = state_e'(state);

      // A state change reloads the timer so that the first WASH/SPIN sample
      // already counts as one; a direct jump is handled the same way.
      if (state != prev_state) begin
        timer_n = timed ? 16'd1 : 16'd0;
      end else if (timed) begin
        timer_n = inc_sat16(timer);
      end

      case (state)
        ST_IDLE:      det_n   = 8'd0;
        ST_FILL:      level_n = inc_sat8(water_level, WATER_FULL_C);
        ST_DETERGENT: det_n   = inc_sat8(det_count, DET_FULL_C);
        ST_DRAIN:     level_n = dec_sat8(water_level);
        default:      ;
      endcase

      drained_n = (state == ST_DRAIN) && (level_n == 8'd0);
      cto_n     = is_wash && (timer_n >= WASH_CYCLES_C);
      sto_n     = is_spin && (timer_n >= SPIN_CYCLES_C);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      water_level    <= 8'd0;
      det_count      <= 8'd0;
      timer          <= 16'd0;
      prev_state     <= ST_IDLE;
      cycle_time_out <= 1'b0;
      drained        <= 1'b0;
      spin_time_out  <= 1'b0;
      fault          <= 1'b0;
    end else begin
      water_level    <= level_n;
      det_count      <= det_n;
      timer          <= timer_n;
      prev_state     <= prev_n;
      cycle_time_out <= cto_n;
      drained        <= drained_n;
      spin_time_out  <= sto_n;
      fault          <= fault_n;
    end
  end

  assign water_level_decrease        = (water_level < WATER_FULL_C);
  assign detergent_quantity_decrease = (det_count < DET_FULL_C);

endmodule
